simd_core_controller: RTL and testbench

Sequencing controller for one SIMD core. On `start` it fetches 32-bit instructions from instruction memory, starting at `start_pc`. It presents each fetched word to the combinational SIMD decoder and receives back the 3-bit instruction type. It then drives the lane execute, writeback and special-load handshakes until a RETURN instruction completes the kernel. It sits between the core's dispatch logic, the instruction memory port, the decoder and the lane datapath.

---
 rtl/simd_core_controller.sv | 170 +++++++++++++++++
 tb/tb_simd_core_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_core_controller.sv
// simd_core_controller
// Sequences one SIMD core through fetch, decode, execute, writeback and
// special-load phases until a RETURN instruction completes the kernel.
// Every handshake strobe is decoded from the registered state alone, so no
// input can reach an output through combinational logic.
module simd_core_controller #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_valid,
    input  logic [31:0]          imem_data,
    output logic [31:0]          instr,
    input  logic [2:0]           type_instruction,
    output logic                 exec_en,
    output logic                 rf_we,
    output logic                 ld_req,
    input  logic                 ld_done,
    output logic                 busy,
    output logic                 done,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_LOAD,
        S_FINISH
    } state_t;

    // Decoder result codes that change control flow; every other code is an
    // ALU/FP operation and takes the EXEC/WB path.
    localparam logic [2:0] T_NOP    = 3'b000;
    localparam logic [2:0] T_LOAD   = 3'b110;
    localparam logic [2:0] T_RETURN = 3'b111;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic [31:0]           r_instr;

    logic                  w_launch;      // accept start: load pc, clear counter
    logic                  w_take_instr;  // latch the fetched word
    logic                  w_retire;      // current instruction completes
    logic                  w_advance;     // step pc to the next instruction

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and datapath control strobes.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case below leaves one unassigned and infers a latch.
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_take_instr = 1'b0;
        w_retire     = 1'b0;
        w_advance    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_take_instr = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (type_instruction)
                    T_NOP: begin
                        w_retire     = 1'b1;
                        w_advance    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    T_LOAD:   w_next_state = S_LOAD;
                    T_RETURN: w_next_state = S_FINISH;
                    default:  w_next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_next_state = S_WB;
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_advance    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_LOAD: begin
                if (ld_done) begin
                    w_retire     = 1'b1;
                    w_advance    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FINISH: begin
                // RETURN retires but leaves pc pointing at itself.
                w_retire     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Program counter, retired-instruction counter and instruction latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_retired <= '0;
            r_instr   <= '0;
        end else begin
            if (w_launch) begin
                r_pc      <= start_pc;
                r_retired <= '0;
            end else begin
                if (w_advance) begin
                    r_pc <= r_pc + PC_ONE;
                end
                if (w_retire) begin
                    r_retired <= r_retired + CNT_ONE;
                end
            end
            // The latch only opens in FETCH, keeping the decoder input stable
            // through EXEC, WB and LOAD.
            if (w_take_instr) begin
                r_instr <= imem_data;
            end
        end
    end

    // Outputs decoded purely from registered state.
    assign busy      = (r_state != S_IDLE);
    assign imem_req  = (r_state == S_FETCH);
    assign exec_en   = (r_state == S_EXEC);
    assign rf_we     = (r_state == S_WB);
    assign ld_req    = (r_state == S_LOAD);
    assign done      = (r_state == S_FINISH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign retired   = r_retired;
    assign instr     = r_instr;

endmodule

// File: tb/tb_simd_core_controller.sv
// tb_simd_core_controller
// Self-checking bench: an instruction-level reference model predicts every
// output each cycle, and directed scenarios pin the model with literal
// latencies, counts and final pc/retired values.
`timescale 1ns/1ps
module tb_simd_core_controller;

    localparam logic [31:0] W_ADD  = 32'h8B00_0000;
    localparam logic [31:0] W_SUB  = 32'hCB00_0000;
    localparam logic [31:0] W_RET  = 32'hFFE0_0000;
    localparam logic [31:0] W_LOAD = 32'hAAA0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [2:0]  type_instruction;
    logic        exec_en;
    logic        rf_we;
    logic        ld_req;
    logic        ld_done = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  pc;
    logic [15:0] retired;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        chk_en   = 1'b0;

    always #5 clk = ~clk;

    simd_core_controller #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .start_pc         (start_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_data        (imem_data),
        .instr            (instr),
        .type_instruction (type_instruction),
        .exec_en          (exec_en),
        .rf_we            (rf_we),
        .ld_req           (ld_req),
        .ld_done          (ld_done),
        .busy             (busy),
        .done             (done),
        .pc               (pc),
        .retired          (retired)
    );

    // Stand-in decoder: the four documented encodings, otherwise the low
    // three bits carry the type for random programs.
    function automatic logic [2:0] tb_decode(input logic [31:0] w);
        case (w)
            W_ADD:   return 3'd3;
            W_SUB:   return 3'd1;
            W_RET:   return 3'd7;
            W_LOAD:  return 3'd6;
            default: return w[2:0];
        endcase
    endfunction

    assign type_instruction = tb_decode(instr);
    assign imem_data        = mem[imem_addr];

    function automatic logic [95:0] outs();
        return {busy, imem_req, exec_en, rf_we, ld_req, done,
                imem_addr, pc, retired, instr};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Reference model at instruction granularity: m_phase 0 = idle,
    // 1 = waiting for fetch data, k+1 = k-th cycle after the fetch completed.
    int          m_phase   = 0;
    logic [7:0]  m_pc      = 8'h00;
    logic [15:0] m_retired = 16'h0000;
    logic [31:0] m_instr   = 32'h0;

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] t;
        int         k;
        bit         alu;
        bit         fin;
        if (rst) begin
            m_phase   = 0;
            m_pc      = 8'h00;
            m_retired = 16'h0000;
            m_instr   = 32'h0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pc      = start_pc;
                m_retired = 16'h0000;
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            if (imem_valid) begin
                m_instr = mem[m_pc];
                m_phase = 2;
            end
        end else begin
            t   = tb_decode(m_instr);
            k   = m_phase - 1;
            alu = (t >= 3'd1) && (t <= 3'd5);
            // Instruction lengths after fetch: NOP 1, ALU 3, RETURN 2,
            // LOAD 1 + cycles until ld_done.
            fin = (t == 3'd0 && k == 1) || (alu && k == 3) ||
                  (t == 3'd6 && k >= 2 && ld_done) || (t == 3'd7 && k == 2);
            if (fin) begin
                m_retired = m_retired + 16'd1;
                if (t == 3'd7) begin
                    m_phase = 0;
                end else begin
                    m_pc    = m_pc + 8'd1;
                    m_phase = 1;
                end
            end else if (!(t == 3'd6 && k >= 2)) begin
                m_phase = m_phase + 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        logic [2:0] t;
        int         k;
        bit         alu;
        if (chk_en && !rst) begin
            t   = tb_decode(m_instr);
            k   = m_phase - 1;
            alu = (t >= 3'd1) && (t <= 3'd5);
            check("cycle_ctrl",
                  {busy, imem_req, exec_en, rf_we, ld_req, done, imem_addr, pc, retired},
                  {m_phase != 0, m_phase == 1, alu && k == 2, alu && k == 3,
                   t == 3'd6 && k >= 2, t == 3'd7 && k == 2, m_pc, m_pc, m_retired});
            check("cycle_instr", instr, m_instr);
        end
    end

    logic [31:0] ex_bits, wb_bits, dn_bits, bz_bits;
    int          run, nfetch, nld, n_done, cyc;
    logic [7:0]  a0;
    logic        bad;
    logic [31:0] rw;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_outputs", outs(), 96'h0);
        repeat (3) begin
            @(negedge clk);
            check("idle_no_req", {busy, imem_req}, 2'b00);
        end

        // ADD, SUB, RETURN from 0x10 with memory always ready.
        mem[8'h10] = W_ADD;
        mem[8'h11] = W_SUB;
        mem[8'h12] = W_RET;
        start = 1'b1; start_pc = 8'h10; imem_valid = 1'b1;
        ex_bits = '0; wb_bits = '0; dn_bits = '0; bz_bits = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (exec_en) ex_bits[c] = 1'b1;
            if (rf_we)   wb_bits[c] = 1'b1;
            if (done)    dn_bits[c] = 1'b1;
            if (busy)    bz_bits[c] = 1'b1;
        end
        check("alu_exec_cycles", ex_bits, 32'h0000_0088);
        check("alu_rfwe_cycles", wb_bits, 32'h0000_0110);
        check("alu_done_cycle",  dn_bits, 32'h0000_0800);
        check("alu_busy_cycles", bz_bits, 32'h0000_0FFE);
        check("alu_final_pc",      pc,      8'h12);
        check("alu_final_retired", retired, 16'd3);

        // Fetch stall: data withheld three cycles on every fetch.
        mem[8'h40] = W_ADD;
        mem[8'h41] = W_RET;
        start = 1'b1; start_pc = 8'h40; imem_valid = 1'b0;
        run = 0; nfetch = 0; bad = 1'b0; a0 = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (imem_req) begin
                if (run == 0) a0 = imem_addr;
                else if (imem_addr !== a0) bad = 1'b1;
                run++;
                imem_valid = (run == 4);
            end else begin
                if (run != 0) begin
                    check("stall_req_len", run, 4);
                    nfetch++;
                end
                run = 0;
                imem_valid = 1'b0;
            end
        end
        check("stall_addr_stable", bad, 1'b0);
        check("stall_fetch_count", nfetch, 2);
        check("stall_final", {pc, retired}, {8'h41, 16'd2});

        // Special LOAD with ld_done in its fifth cycle; stray ld_done in FETCH.
        mem[8'h80] = W_LOAD;
        mem[8'h81] = W_RET;
        start = 1'b1; start_pc = 8'h80; imem_valid = 1'b1;
        nld = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ld_req) nld++;
            ld_done    = ld_req && (nld == 5);
            imem_valid = 1'b1;
            if (c == 1) begin
                imem_valid = 1'b0;
                ld_done    = 1'b1;
            end
            if (c == 2) check("stray_ld_done_fetch", {imem_req, busy, ld_req}, 3'b110);
        end
        ld_done = 1'b0;
        check("load_req_cycles", nld, 5);
        check("load_final", {pc, retired}, {8'h81, 16'd2});

        // pc wrap from 0xFF and an ignored start mid-run.
        mem[8'hFF] = 32'h0;
        mem[8'h00] = W_RET;
        start = 1'b1; start_pc = 8'hFF; imem_valid = 1'b1;
        dn_bits = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start    = (c == 2);
            start_pc = (c == 2) ? 8'h33 : 8'hFF;
            if (done) dn_bits[c] = 1'b1;
        end
        check("wrap_done_cycle", dn_bits, 32'h0000_0020);
        check("wrap_final", {pc, retired}, {8'h00, 16'd2});

        // Reset while waiting in LOAD, then a clean restart.
        mem[8'h20] = W_LOAD;
        mem[8'h21] = W_RET;
        start = 1'b1; start_pc = 8'h20; imem_valid = 1'b1; ld_done = 1'b0;
        nld = 0; cyc = 0;
        while (nld < 3 && cyc < 30) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (ld_req) nld++;
        end
        check("rst_load_reached", nld, 3);
        #2 rst = 1'b1;
        #1 check("rst_load_outputs", outs(), 96'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_idle_no_req", {busy, imem_req}, 2'b00);
        end
        start = 1'b1; start_pc = 8'h20;
        nld = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) check("rst_restart_fetch", {imem_req, imem_addr, retired}, {1'b1, 8'h20, 16'd0});
            if (ld_req) nld++;
            ld_done = ld_req && (nld == 2);
        end
        ld_done = 1'b0;
        check("rst_restart_final", {pc, retired, nld}, {8'h21, 16'd2, 32'd2});

        // Random programs and random handshakes, checked by the model.
        for (int i = 0; i < 256; i++) begin
            rw     = $urandom();
            mem[i] = {rw[31:4], 1'b1, 3'($urandom_range(0, 7))};
        end
        n_done = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (c == 3000) begin
                #2 rst = 1'b1;
                #1 check("rand_rst_outputs", outs(), 96'h0);
                @(negedge clk);
                rst = 1'b0;
            end
            start      = ($urandom_range(0, 9) == 0);
            start_pc   = 8'($urandom());
            imem_valid = ($urandom_range(0, 99) < 65);
            ld_done    = ($urandom_range(0, 99) < 35);
            if (done) n_done++;
        end
        start = 1'b0; imem_valid = 1'b0; ld_done = 1'b0;
        check("rand_kernels_completed", n_done >= 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
